glb_read_arbiter: RTL and testbench
===================================

# glb_read_arbiter

Shares the single global-buffer (GLB) read port between NUM_REQ router clients (iact, weight, psum routers) feeding the PE scratchpads. A client requests the port, and the arbiter grants it in round-robin order. The grant is held for a burst while the client keeps its request asserted. The arbiter multiplexes the owner's address onto the GLB and steers the returning read data back with a per-client valid. It sits between the router bank and the GLB, replacing each router's direct GLB read connection.

## Interface
- DATA_BITWIDTH, 16, GLB word width
- ADDR_BITWIDTH_GLB, 10, GLB address width
- NUM_REQ, 3, number of requesting clients (2..8)
- MAX_BURST, 32, max reads per grant when burst limit compiled in (2..255)

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req  in  NUM_REQ  per-client read request; bit i = client i
- addr  in  NUM_REQ*ADDR_BITWIDTH_GLB  per-client read address, client i at bits [i*A +: A]
- gnt  out  NUM_REQ  one-hot grant (registered); all-zero when idle
- rvalid  out  NUM_REQ  one-hot, rdata valid for client i this cycle
- rdata  out  DATA_BITWIDTH  read data, broadcast to all clients
- glb_read_req  out  1  GLB read enable
- glb_r_addr  out  ADDR_BITWIDTH_GLB  GLB read address
- glb_r_data  in  DATA_BITWIDTH  GLB read data, valid one cycle after glb_read_req

## Operation
- State machine has two states: IDLE and GRANT. It also keeps a registered owner index, a round-robin pointer rr_ptr and a burst counter burst_cnt (8 bits).
- IDLE
  - If req is nonzero, owner = first set bit searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Set gnt[owner] and go to GRANT. burst_cnt = 0.
  - Otherwise stay in IDLE.
- GRANT
  - Combinational outputs: glb_read_req = req[owner]; glb_r_addr = addr[owner].
  - Each cycle with glb_read_req=1 increments burst_cnt.
- Release from GRANT when req[owner]=0, or (burst limit only) when a read is issued with burst_cnt == MAX_BURST-1.
  - On release, the next state is IDLE, gnt clears and rr_ptr = owner+1 mod NUM_REQ.
  - The read issued in the release cycle completes normally.
- Outputs outside GRANT: glb_read_req=0 and glb_r_addr = 0.
- Read return
  - rvalid[i] is registered: it equals (glb_read_req && owner==i) from the previous cycle.
  - rdata = glb_r_data, passed through combinationally.
- Data returned after a release is still tagged to the old owner through rvalid.
- Non-owner requests are ignored until re-arbitration. Clients must hold req and addr until they see gnt.
- Reset values: state=IDLE, gnt=0, rvalid=0, rr_ptr=0, owner=0, burst_cnt=0, glb_read_req=0, glb_r_addr=0.
- Reset mid-burst aborts immediately. No rvalid is issued for the read that was in flight.

## Timing
- Grant latency: req rises in cycle t (arbiter in IDLE) → gnt in t+1 → first glb_read_req in t+1 if req still high.
- Read data latency: glb_read_req at cycle n → rvalid/rdata at n+1.
- Sustained throughput is one read per cycle during a burst.
- Each release costs one IDLE cycle before the next grant, so the minimum owner-switch gap is 1 cycle with no GLB read.
- Simultaneous requests are resolved strictly by rr_ptr order. No client waits more than NUM_REQ-1 grants.
- If req[owner] drops and re-rises in the same IDLE cycle, it competes normally from rr_ptr.

## Configuration
- GLB_ARB_BURST_LIMIT_EN
  - Defined: a grant ends after MAX_BURST reads even if req stays high. The client re-arbitrates from the back of the round-robin order.
  - Undefined: a grant lasts until the owner drops req. MAX_BURST and the limit compare are unused, but burst_cnt still counts and wraps at 255.

## Test plan
- Single client
  - Stimulus: reset, then req=3'b001 with addr0=100 for 25 cycles, incrementing each cycle.
  - Required: gnt=001 one cycle later; glb_r_addr runs 100..124; 25 rvalid[0] pulses, each carrying GLB word addr+1 cycle earlier.
- Three-way contention
  - Stimulus: req=111 asserted together, each client doing a 4-read burst then dropping req.
  - Required: grants in order 0,1,2 with one idle cycle between bursts; rr_ptr=0 afterward.
- Fairness
  - Stimulus: client 0 re-requests immediately after its release while client 2 is waiting.
  - Required: client 2 is granted before client 0.
- Burst limit (GLB_ARB_BURST_LIMIT_EN, MAX_BURST=4)
  - Stimulus: req=011 held high.
  - Required: alternating 4-read bursts 0,1,0,1; without the macro, client 0 keeps gnt indefinitely.
- Reset mid-burst
  - Stimulus: assert reset during client 1's third read.
  - Required: next cycle gnt=0, rvalid=0, glb_read_req=0; after release, req=010 is granted with rr_ptr starting at 0.
- Read data tagging at release
  - Stimulus: release client 0 with a read in the release cycle.
  - Required: rvalid[0] in the following cycle while gnt=0.

Source files
------------

// File: rtl/glb_read_arbiter_if.sv
// ---------------------------------------------------------------------------
// glb_read_arbiter_if
// Bundle between the router clients / GLB read port and glb_read_arbiter.
//   req          per-client read request, bit i = client i
//   addr         per-client read address, client i at [i*A +: A]
//   gnt          one-hot grant back to the clients
//   rvalid       one-hot "rdata belongs to client i this cycle"
//   rdata        read data broadcast to every client
//   glb_read_req GLB read enable
//   glb_r_addr   GLB read address
//   glb_r_data   GLB read data, one cycle after glb_read_req
// Modports:
//   slave  - the arbiter
//   master - the environment (router bank plus the GLB read port)
// ---------------------------------------------------------------------------
interface glb_read_arbiter_if #(
  parameter int DATA_BITWIDTH     = 16,
  parameter int ADDR_BITWIDTH_GLB = 10,
  parameter int NUM_REQ           = 3
);
  logic [NUM_REQ-1:0]                   req;
  logic [NUM_REQ*ADDR_BITWIDTH_GLB-1:0] addr;
  logic [NUM_REQ-1:0]                   gnt;
  logic [NUM_REQ-1:0]                   rvalid;
  logic [DATA_BITWIDTH-1:0]             rdata;
  logic                                 glb_read_req;
  logic [ADDR_BITWIDTH_GLB-1:0]         glb_r_addr;
  logic [DATA_BITWIDTH-1:0]             glb_r_data;

  modport slave (
    input  req, addr, glb_r_data,
    output gnt, rvalid, rdata, glb_read_req, glb_r_addr
  );

  modport master (
    output req, addr, glb_r_data,
    input  gnt, rvalid, rdata, glb_read_req, glb_r_addr
  );
endinterface

// File: rtl/glb_read_arbiter.sv
// ---------------------------------------------------------------------------
// glb_read_arbiter
// Shares the single GLB read port between NUM_REQ router clients. Clients are
// granted in round-robin order; a grant lasts while the owner keeps req high.
// The owner's address is muxed onto the GLB and returning data is tagged to
// the issuing client with a registered one-hot rvalid.
//
// Ports:
//   clk    clock
//   reset  synchronous, active-high reset
//   bus    glb_read_arbiter_if.slave (req/addr in, gnt/rvalid/rdata out,
//          glb_read_req/glb_r_addr out, glb_r_data in)
//
// Build option:
//   GLB_ARB_BURST_LIMIT_EN  when defined, a grant also ends after MAX_BURST
//                           reads, sending the owner to the back of the
//                           round-robin order. When undefined, MAX_BURST is
//                           unused and burst_cnt simply wraps at 255.
// ---------------------------------------------------------------------------
module glb_read_arbiter #(
  parameter int DATA_BITWIDTH     = 16,
  parameter int ADDR_BITWIDTH_GLB = 10,
  parameter int NUM_REQ           = 3,
  parameter int MAX_BURST         = 32
) (
  input  logic               clk,
  input  logic               reset,
  glb_read_arbiter_if.slave  bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SUM_W = PTR_W + 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  state_e                       state_q, state_d;
  logic [PTR_W-1:0]             owner_q, owner_d;
  logic [PTR_W-1:0]             rr_ptr_q, rr_ptr_d;
  logic [7:0]                   burst_cnt_q, burst_cnt_d;
  logic [NUM_REQ-1:0]           gnt_q, gnt_d;
  logic [NUM_REQ-1:0]           rvalid_q, rvalid_d;

  logic [ADDR_BITWIDTH_GLB-1:0] addr_arr [NUM_REQ];
  logic                         rd_en;
  logic [ADDR_BITWIDTH_GLB-1:0] rd_addr;
  logic [PTR_W-1:0]             owner_inc;
  logic [SUM_W-1:0]             rr_sum;
  logic [PTR_W-1:0]             rr_cand;
  logic [PTR_W-1:0]             rr_pick;
  logic                         rr_found;

  // Unpack the flat address bus so the owner can select its slot directly.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_addr
    assign addr_arr[gi] = bus.addr[gi*ADDR_BITWIDTH_GLB +: ADDR_BITWIDTH_GLB];
  end

  // Round-robin search: first requester at rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  // The sum never reaches 2*NUM_REQ, so one conditional subtract is the modulo.
  always_comb begin
    // NOTE: every variable gets a value before any branch, so no path can
    // leave one unassigned and infer a latch.
    rr_found = 1'b0;
    rr_pick  = '0;
    rr_sum   = '0;
    rr_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_sum = {1'b0, rr_ptr_q} + SUM_W'(k);
      if (rr_sum >= SUM_W'(NUM_REQ)) begin
        rr_sum = rr_sum - SUM_W'(NUM_REQ);
      end
      rr_cand = rr_sum[PTR_W-1:0];
      if (!rr_found && bus.req[rr_cand]) begin
        rr_found = 1'b1;
        rr_pick  = rr_cand;
      end
    end
  end

  assign owner_inc = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    gnt_d       = gnt_q;
    rd_en       = 1'b0;
    rd_addr     = '0;

    unique case (state_q)
      S_IDLE: begin
        if (rr_found) begin
          owner_d     = rr_pick;
          gnt_d       = NUM_REQ'(1) << rr_pick;
          burst_cnt_d = '0;
          state_d     = S_GRANT;
        end
      end

      S_GRANT: begin
        // The owner's req doubles as the GLB read enable for this cycle.
        rd_en   = bus.req[owner_q];
        rd_addr = addr_arr[owner_q];
        if (rd_en) begin
          burst_cnt_d = burst_cnt_q + 8'd1;
        end
`ifdef GLB_ARB_BURST_LIMIT_EN
        // A read issued at count MAX_BURST-1 is the last of the burst; it
        // still completes and returns data next cycle.
        if (!rd_en || (burst_cnt_q == 8'(MAX_BURST - 1))) begin
`else
        if (!rd_en) begin
`endif
          state_d  = S_IDLE;
          gnt_d    = '0;
          rr_ptr_d = owner_inc;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Data returns one cycle after the read; tag it to the issuing owner
    // even if the grant is released in the same cycle.
    rvalid_d = rd_en ? (NUM_REQ'(1) << owner_q) : '0;
  end

  // NOTE: synchronous reset; clearing rvalid here drops any read in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      gnt_q       <= '0;
      rvalid_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // computed from the same clock edge.
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.rvalid       = rvalid_q;
  assign bus.rdata        = bus.glb_r_data;
  assign bus.glb_read_req = rd_en;
  assign bus.glb_r_addr   = rd_addr;

endmodule

// File: tb/tb_glb_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_glb_read_arbiter
// Directed bench for glb_read_arbiter. Inputs are driven on the falling edge
// and outputs are observed 1 time unit later, so registered outputs reflect
// the previous rising edge and combinational outputs reflect the new inputs.
// The GLB is modelled as a one-cycle memory returning {6'h2A, address}.
// ---------------------------------------------------------------------------
module tb_glb_read_arbiter;
  localparam int DW = 16;
  localparam int AW = 10;
  localparam int NR = 3;
`ifdef GLB_ARB_BURST_LIMIT_EN
  localparam int MB = 4;
`else
  localparam int MB = 32;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  glb_read_arbiter_if #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH_GLB(AW), .NUM_REQ(NR)) bus ();

  glb_read_arbiter #(
    .DATA_BITWIDTH    (DW),
    .ADDR_BITWIDTH_GLB(AW),
    .NUM_REQ          (NR),
    .MAX_BURST        (MB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] glb_word(input logic [AW-1:0] a);
    return {6'h2A, a};
  endfunction

  // GLB read port model: data valid one cycle after the read enable.
  always @(posedge clk) begin
    bus.glb_r_data <= bus.glb_read_req ? glb_word(bus.glb_r_addr) : 16'hDEAD;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_addr(input int c, input int a);
    bus.addr[c*AW +: AW] = AW'(a);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    bus.req  = '0;
    bus.addr = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    bus.req  = 3'b111;
    bus.addr = '1;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_checks++; if (bus.gnt !== 3'b000) $display("FAIL reset_gnt: got %b expected 000", bus.gnt); else n_pass++;
    n_checks++; if (bus.rvalid !== 3'b000) $display("FAIL reset_rvalid: got %b expected 000", bus.rvalid); else n_pass++;
    n_checks++; if (bus.glb_read_req !== 1'b0) $display("FAIL reset_glb_read_req: got %b expected 0", bus.glb_read_req); else n_pass++;
    n_checks++; if (bus.glb_r_addr !== 10'd0) $display("FAIL reset_glb_r_addr: got %0d expected 0", bus.glb_r_addr); else n_pass++;
    reset   = 1'b0;
    bus.req = '0;
    @(negedge clk);
    #1;
    n_checks++; if (bus.gnt !== 3'b000) $display("FAIL reset_idle_gnt: got %b expected 000", bus.gnt); else n_pass++;
  endtask

  task automatic test_single_client();
    int pulses;
    pulses = 0;
    do_reset();
    bus.req = 3'b001;
    set_addr(0, 100);
    #1;
    n_checks++; if (bus.gnt !== 3'b000) $display("FAIL single_pre_gnt: got %b expected 000", bus.gnt); else n_pass++;
    @(negedge clk);
    for (int i = 0; i < 25; i++) begin
      set_addr(0, 100 + i);
      #1;
      n_checks++; if (bus.gnt !== 3'b001) $display("FAIL single_gnt[%0d]: got %b expected 001", i, bus.gnt); else n_pass++;
      n_checks++; if (bus.glb_read_req !== 1'b1) $display("FAIL single_rd_en[%0d]: got %b expected 1", i, bus.glb_read_req); else n_pass++;
      n_checks++; if (bus.glb_r_addr !== AW'(100 + i)) $display("FAIL single_addr[%0d]: got %0d expected %0d", i, bus.glb_r_addr, 100 + i); else n_pass++;
      if (bus.rvalid[0]) pulses++;
      if (i > 0) begin
        n_checks++; if (bus.rvalid !== 3'b001) $display("FAIL single_rvalid[%0d]: got %b expected 001", i, bus.rvalid); else n_pass++;
        n_checks++; if (bus.rdata !== glb_word(AW'(99 + i))) $display("FAIL single_rdata[%0d]: got %h expected %h", i, bus.rdata, glb_word(AW'(99 + i))); else n_pass++;
      end
      @(negedge clk);
    end
    bus.req = 3'b000;
    #1;
    if (bus.rvalid[0]) pulses++;
    n_checks++; if (bus.rvalid !== 3'b001) $display("FAIL single_last_rvalid: got %b expected 001", bus.rvalid); else n_pass++;
    n_checks++; if (bus.rdata !== glb_word(AW'(124))) $display("FAIL single_last_rdata: got %h expected %h", bus.rdata, glb_word(AW'(124))); else n_pass++;
    n_checks++; if (bus.glb_read_req !== 1'b0) $display("FAIL single_release_rd_en: got %b expected 0", bus.glb_read_req); else n_pass++;
    n_checks++; if (bus.gnt !== 3'b001) $display("FAIL single_release_gnt: got %b expected 001", bus.gnt); else n_pass++;
    @(negedge clk);
    #1;
    if (bus.rvalid[0]) pulses++;
    n_checks++; if (bus.gnt !== 3'b000) $display("FAIL single_idle_gnt: got %b expected 000", bus.gnt); else n_pass++;
    n_checks++; if (bus.rvalid !== 3'b000) $display("FAIL single_idle_rvalid: got %b expected 000", bus.rvalid); else n_pass++;
    n_checks++; if (pulses !== 25) $display("FAIL single_pulse_count: got %0d expected 25", pulses); else n_pass++;
  endtask

  task automatic test_contention();
    logic [NR-1:0] exp_g;
    int            base;
    do_reset();
    bus.req = 3'b111;
    #1;
    n_checks++; if (bus.gnt !== 3'b000) $display("FAIL cont_pre_gnt: got %b expected 000", bus.gnt); else n_pass++;
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      exp_g = NR'(1) << c;
      base  = 10 * (c + 1);
      for (int k = 0; k < 4; k++) begin
        set_addr(c, base + k);
        #1;
        n_checks++; if (bus.gnt !== exp_g) $display("FAIL cont_gnt[c%0d,k%0d]: got %b expected %b", c, k, bus.gnt, exp_g); else n_pass++;
        n_checks++; if (bus.glb_r_addr !== AW'(base + k)) $display("FAIL cont_addr[c%0d,k%0d]: got %0d expected %0d", c, k, bus.glb_r_addr, base + k); else n_pass++;
        if (k > 0) begin
          n_checks++; if (bus.rvalid !== exp_g) $display("FAIL cont_rvalid[c%0d,k%0d]: got %b expected %b", c, k, bus.rvalid, exp_g); else n_pass++;
        end
        @(negedge clk);
      end
      bus.req[c] = 1'b0;
      #1;
      n_checks++; if (bus.rdata !== glb_word(AW'(base + 3))) $display("FAIL cont_last_rdata[c%0d]: got %h expected %h", c, bus.rdata, glb_word(AW'(base + 3))); else n_pass++;
      n_checks++; if (bus.glb_read_req !== 1'b0) $display("FAIL cont_release_rd_en[c%0d]: got %b expected 0", c, bus.glb_read_req); else n_pass++;
      @(negedge clk);
      #1;
      n_checks++; if (bus.gnt !== 3'b000) $display("FAIL cont_idle_gnt[c%0d]: got %b expected 000", c, bus.gnt); else n_pass++;
      n_checks++; if (bus.glb_read_req !== 1'b0) $display("FAIL cont_idle_rd_en[c%0d]: got %b expected 0", c, bus.glb_read_req); else n_pass++;
      @(negedge clk);
    end
    // Pointer wrapped back to 0: a full request set must pick client 0.
    bus.req = 3'b111;
    @(negedge clk);
    #1;
    n_checks++; if (bus.gnt !== 3'b001) $display("FAIL cont_rr_wrap_gnt: got %b expected 001", bus.gnt); else n_pass++;
  endtask

  task automatic test_fairness();
    do_reset();
    bus.req = 3'b101;
    set_addr(0, 40);
    set_addr(2, 60);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      #1;
      n_checks++; if (bus.gnt !== 3'b001) $display("FAIL fair_gnt0[%0d]: got %b expected 001", k, bus.gnt); else n_pass++;
      @(negedge clk);
    end
    bus.req[0] = 1'b0;
    @(negedge clk);
    bus.req[0] = 1'b1;   // re-request during the idle cycle
    #1;
    n_checks++; if (bus.gnt !== 3'b000) $display("FAIL fair_idle_gnt: got %b expected 000", bus.gnt); else n_pass++;
    @(negedge clk);
    #1;
    n_checks++; if (bus.gnt !== 3'b100) $display("FAIL fair_gnt2: got %b expected 100", bus.gnt); else n_pass++;
    n_checks++; if (bus.glb_r_addr !== AW'(60)) $display("FAIL fair_addr2: got %0d expected 60", bus.glb_r_addr); else n_pass++;
    @(negedge clk);
    bus.req[2] = 1'b0;
    #1;
    n_checks++; if (bus.rvalid !== 3'b100) $display("FAIL fair_rvalid2: got %b expected 100", bus.rvalid); else n_pass++;
    n_checks++; if (bus.rdata !== glb_word(AW'(60))) $display("FAIL fair_rdata2: got %h expected %h", bus.rdata, glb_word(AW'(60))); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_checks++; if (bus.gnt !== 3'b001) $display("FAIL fair_regrant0: got %b expected 001", bus.gnt); else n_pass++;
  endtask

`ifdef GLB_ARB_BURST_LIMIT_EN
  task automatic test_burst_limit();
    logic [NR-1:0] exp_g;
    int            c;
    int            base;
    do_reset();
    bus.req = 3'b011;
    set_addr(0, 200);
    set_addr(1, 300);
    @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      c     = b % 2;
      base  = (c == 0) ? 200 : 300;
      exp_g = NR'(1) << c;
      for (int k = 0; k < 4; k++) begin
        #1;
        n_checks++; if (bus.gnt !== exp_g) $display("FAIL limit_gnt[b%0d,k%0d]: got %b expected %b", b, k, bus.gnt, exp_g); else n_pass++;
        n_checks++; if (bus.glb_read_req !== 1'b1) $display("FAIL limit_rd_en[b%0d,k%0d]: got %b expected 1", b, k, bus.glb_read_req); else n_pass++;
        n_checks++; if (bus.glb_r_addr !== AW'(base)) $display("FAIL limit_addr[b%0d,k%0d]: got %0d expected %0d", b, k, bus.glb_r_addr, base); else n_pass++;
        @(negedge clk);
      end
      // Limit release: idle cycle still carries the last read's data.
      #1;
      n_checks++; if (bus.gnt !== 3'b000) $display("FAIL limit_idle_gnt[b%0d]: got %b expected 000", b, bus.gnt); else n_pass++;
      n_checks++; if (bus.rvalid !== exp_g) $display("FAIL limit_tag_rvalid[b%0d]: got %b expected %b", b, bus.rvalid, exp_g); else n_pass++;
      n_checks++; if (bus.rdata !== glb_word(AW'(base))) $display("FAIL limit_tag_rdata[b%0d]: got %h expected %h", b, bus.rdata, glb_word(AW'(base))); else n_pass++;
      n_checks++; if (bus.glb_read_req !== 1'b0) $display("FAIL limit_idle_rd_en[b%0d]: got %b expected 0", b, bus.glb_read_req); else n_pass++;
      @(negedge clk);
    end
  endtask
`else
  task automatic test_no_limit();
    do_reset();
    bus.req = 3'b011;
    set_addr(0, 5);
    set_addr(1, 7);
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      #1;
      n_checks++; if (bus.gnt !== 3'b001) $display("FAIL nolimit_gnt[%0d]: got %b expected 001", i, bus.gnt); else n_pass++;
      n_checks++; if (bus.glb_read_req !== 1'b1) $display("FAIL nolimit_rd_en[%0d]: got %b expected 1", i, bus.glb_read_req); else n_pass++;
      @(negedge clk);
    end
  endtask
`endif

  task automatic test_reset_mid_burst();
    do_reset();
    bus.req = 3'b001;
    set_addr(0, 1);
    set_addr(1, 80);
    @(negedge clk);
    #1;
    n_checks++; if (bus.gnt !== 3'b001) $display("FAIL rmb_gnt0: got %b expected 001", bus.gnt); else n_pass++;
    @(negedge clk);
    bus.req = 3'b010;    // client 0 releases, pointer moves to 1
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      set_addr(1, 80 + k);
      if (k == 2) reset = 1'b1;
      #1;
      n_checks++; if (bus.gnt !== 3'b010) $display("FAIL rmb_gnt1[%0d]: got %b expected 010", k, bus.gnt); else n_pass++;
      n_checks++; if (bus.glb_r_addr !== AW'(80 + k)) $display("FAIL rmb_addr1[%0d]: got %0d expected %0d", k, bus.glb_r_addr, 80 + k); else n_pass++;
      @(negedge clk);
    end
    #1;
    n_checks++; if (bus.gnt !== 3'b000) $display("FAIL rmb_after_gnt: got %b expected 000", bus.gnt); else n_pass++;
    n_checks++; if (bus.rvalid !== 3'b000) $display("FAIL rmb_after_rvalid: got %b expected 000", bus.rvalid); else n_pass++;
    n_checks++; if (bus.glb_read_req !== 1'b0) $display("FAIL rmb_after_rd_en: got %b expected 0", bus.glb_read_req); else n_pass++;
    reset   = 1'b0;
    bus.req = 3'b011;    // pointer back at 0 after reset, so client 0 wins
    @(negedge clk);
    #1;
    n_checks++; if (bus.gnt !== 3'b001) $display("FAIL rmb_rr_reset_gnt: got %b expected 001", bus.gnt); else n_pass++;
    bus.req = 3'b010;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    n_checks++; if (bus.gnt !== 3'b010) $display("FAIL rmb_regrant1: got %b expected 010", bus.gnt); else n_pass++;
  endtask

  task automatic test_tagging();
    do_reset();
    bus.req = 3'b001;
    set_addr(0, 90);
    set_addr(1, 95);
    @(negedge clk);
    #1;
    n_checks++; if (bus.glb_read_req !== 1'b1) $display("FAIL tag_rd_en0: got %b expected 1", bus.glb_read_req); else n_pass++;
    @(negedge clk);
    bus.req = 3'b010;    // owner drops, client 1 already waiting
    #1;
    n_checks++; if (bus.rvalid !== 3'b001) $display("FAIL tag_rvalid0: got %b expected 001", bus.rvalid); else n_pass++;
    n_checks++; if (bus.rdata !== glb_word(AW'(90))) $display("FAIL tag_rdata0: got %h expected %h", bus.rdata, glb_word(AW'(90))); else n_pass++;
    n_checks++; if (bus.glb_read_req !== 1'b0) $display("FAIL tag_release_rd_en: got %b expected 0", bus.glb_read_req); else n_pass++;
    @(negedge clk);
    #1;
    n_checks++; if (bus.rvalid !== 3'b000) $display("FAIL tag_idle_rvalid: got %b expected 000", bus.rvalid); else n_pass++;
    n_checks++; if (bus.gnt !== 3'b000) $display("FAIL tag_idle_gnt: got %b expected 000", bus.gnt); else n_pass++;
    @(negedge clk);
    #1;
    n_checks++; if (bus.gnt !== 3'b010) $display("FAIL tag_gnt1: got %b expected 010", bus.gnt); else n_pass++;
    n_checks++; if (bus.glb_r_addr !== AW'(95)) $display("FAIL tag_addr1: got %0d expected 95", bus.glb_r_addr); else n_pass++;
    @(negedge clk);
    #1;
    n_checks++; if (bus.rvalid !== 3'b010) $display("FAIL tag_rvalid1: got %b expected 010", bus.rvalid); else n_pass++;
    n_checks++; if (bus.rdata !== glb_word(AW'(95))) $display("FAIL tag_rdata1: got %h expected %h", bus.rdata, glb_word(AW'(95))); else n_pass++;
  endtask

  initial begin
    reset    = 1'b1;
    bus.req  = '0;
    bus.addr = '0;
    @(negedge clk);
    test_reset();
`ifdef GLB_ARB_BURST_LIMIT_EN
    test_burst_limit();
`else
    test_single_client();
    test_contention();
    test_no_limit();
`endif
    test_fairness();
    test_reset_mid_burst();
    test_tagging();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
